uio_bus_arbiter: RTL and testbench
==================================

# uio_bus_arbiter

Time-shares the 8-bit bidirectional user IO port (uio_in / uio_out / uio_oe) of the top-level tile among N_REQ internal requesters. A round-robin arbiter grants the bus to one owner at a time. Write beats drive the pins and read beats sample them. A guaranteed turnaround gap between owners prevents drive contention. Sits between the tile top module's uio pins and the internal peripherals; all bus-facing outputs are registered.

## Interface
- N_REQ, 3: number of requesters, legal 2..8
- HOLD_MAX, 4: max beats per grant before forced release, ≥1
- TURN_CYC, 1: turnaround cycles after each ownership, ≥1
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- ena  in  1  tile enable; 0 blocks new grants
- req  in  N_REQ  per-requester bus request
- drive  in  N_REQ  per-requester direction, 1=write pins, 0=read pins
- last  in  N_REQ  marks final beat of requester's transfer
- wdata  in  8*N_REQ  write byte, requester i at [8i+7:8i]
- uio_in  in  8  pin input path
- uio_out  out  8  pin output path (registered)
- uio_oe  out  8  pin output enable, all bits equal (registered)
- gnt  out  N_REQ  one-hot grant (registered)
- rdata  out  8  sampled read byte (registered)
- rvalid  out  N_REQ  one-hot, rdata valid for requester i (registered)

## Operation
- FSM states: ARB, OWN, TURN. Reset state ARB.
- ARB:
  - gnt=0.
  - If ena=1 and req≠0, pick the first set req bit searching upward, with wrap, from (last owner + 1) mod N_REQ.
  - Latch owner index and drive[owner]; clear beat counter; next edge → OWN with gnt[owner]=1.
  - Else stay in ARB.
- Round-robin pointer after reset: requester 0 searched first.
- OWN: gnt[owner]=1. A cycle is a beat iff req[owner]=1.
  - Write beat (latched drive=1): at the edge, uio_out<=wdata[owner], uio_oe<=8'hFF.
  - Read beat (latched drive=0): at the edge, rdata<=uio_in, rvalid<=one-hot(owner).
  - Any edge with no write beat: uio_oe<=0, uio_out holds.
  - Any edge with no read beat: rvalid<=0, rdata holds.
  - Beat with last[owner]=1, or beat that brings the counter to HOLD_MAX → TURN.
  - Cycle with req[owner]=0 is an abort: no beat, no sample → TURN.
  - drive changes during OWN are ignored; the latched value is used.
  - Mid-transfer ena=0 has no effect; the owner finishes.
- TURN: gnt=0 for TURN_CYC cycles (down-counter), then → ARB.
- Beat counter width clog2(HOLD_MAX+1). It saturates at HOLD_MAX and never wraps.
- Forced release by HOLD_MAX: the requester keeps req high and competes again via round-robin behind the others.
- rst=1 at any edge, including mid-OWN or TURN:
  - state=ARB, pointer to requester 0.
  - gnt=0, uio_oe=0, uio_out=0, rdata=0, rvalid=0, counters=0.
  - rst dominates all other inputs.

## Timing
- Grant latency: req seen in ARB at cycle t → gnt at t+1.
- Write pipeline: beat in cycle t → uio_out/uio_oe valid in cycle t+1 only.
- Read pipeline: uio_in sampled at the end of beat cycle t → rdata/rvalid in cycle t+1 only.
- Handover: final beat at t, TURN t+1..t+TURN_CYC, ARB at t+TURN_CYC+1, next gnt at t+TURN_CYC+2.
  - gnt is low for ≥TURN_CYC+1 cycles.
  - uio_oe is low for ≥TURN_CYC+1 cycles between the last write of one owner and the first write of the next.
- Throughput within OWN: one beat per cycle.
- gnt never has more than one bit set.
- uio_oe is only 8'h00 or 8'hFF.

## Test plan
- Reset: hold rst 2 cycles with req=3'b111 → gnt=0, uio_oe=0, uio_out=0, rdata=0, rvalid=0; first grant after release goes to requester 0.
- Single write: req0=1, drive0=1, wdata0=8'hA5, last0 on 3rd beat.
  - Expect gnt=001 for exactly 3 cycles.
  - Expect uio_oe=FF and uio_out=A5 in each of the 3 following cycles, then uio_oe=0.
  - Expect gnt=0 for TURN_CYC+1 cycles.
- Read: req1=1, drive1=0, uio_in=8'h3C, last1 on 1st beat → rdata=3C, rvalid=010 for one cycle after the beat; uio_oe stays 0 throughout.
- Round-robin: req=111 held, all last=1 → grant order 0,1,2,0,1, each grant 1 cycle, separated by TURN_CYC+1 idle cycles.
- Forced release: HOLD_MAX=4, req0 and req1 held, last=0 → 4 beats to 0, then 4 to 1, then 0 again; counter never exceeds 4.
- Abort, enable, reset:
  - req0 drops after 1 of 3 beats → no further beat, TURN entered.
  - ena=0 in ARB with req≠0 → no grant until ena=1.
  - rst asserted during a write beat → uio_oe=0 and gnt=0 at the next edge.

Source files
------------

// File: rtl/uio_bus_arbiter_if.sv
// Requester-side bundle of the uio bus arbiter: per-requester request and
// write data in, one-hot grant and read return out.
interface uio_bus_arbiter_if #(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   drive;
  logic [N_REQ-1:0]   last;
  logic [8*N_REQ-1:0] wdata;
  logic [N_REQ-1:0]   gnt;
  logic [7:0]         rdata;
  logic [N_REQ-1:0]   rvalid;

  modport master (
    output req, drive, last, wdata,
    input  gnt, rdata, rvalid
  );

  modport slave (
    input  req, drive, last, wdata,
    output gnt, rdata, rvalid
  );
endinterface

// File: rtl/uio_bus_arbiter.sv
// Round-robin time-sharing of the tile's bidirectional uio pins among N_REQ
// internal requesters, with a turnaround gap between owners.
module uio_bus_arbiter #(
  parameter int N_REQ    = 3,
  parameter int HOLD_MAX = 4,
  parameter int TURN_CYC = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [7:0]            uio_in,
  output logic [7:0]            uio_out,
  output logic [7:0]            uio_oe,
  uio_bus_arbiter_if.slave      bus
);

  localparam int IDX_W  = $clog2(N_REQ);
  localparam int CNT_W  = $clog2(HOLD_MAX + 1);
  localparam int TURN_W = $clog2(TURN_CYC + 1);

  typedef enum logic [1:0] {ARB, OWN, TURN} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   owner, owner_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt;
  logic               drive_lat, drive_lat_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;
  logic [TURN_W-1:0]  turn_cnt, turn_cnt_nxt;
  logic [N_REQ-1:0]   gnt_q, gnt_nxt;
  logic [7:0]         out_q, out_nxt;
  logic [7:0]         oe_q, oe_nxt;
  logic [7:0]         rdata_q, rdata_nxt;
  logic [N_REQ-1:0]   rvalid_q, rvalid_nxt;
  logic [IDX_W-1:0]   pick;

  // First set request at or after the pointer, wrapping around.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] sel;
    logic             found;
    int               idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(p) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && r[idx]) begin
        found = 1'b1;
        sel   = IDX_W'(idx);
      end
    end
    return sel;
  endfunction

  function automatic logic [N_REQ-1:0] one_hot(input logic [IDX_W-1:0] i);
    return {{(N_REQ-1){1'b0}}, 1'b1} << i;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB;
      owner     <= '0;
      ptr       <= '0;
      drive_lat <= 1'b0;
      cnt       <= '0;
      turn_cnt  <= '0;
      gnt_q     <= '0;
      out_q     <= '0;
      oe_q      <= '0;
      rdata_q   <= '0;
      rvalid_q  <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      ptr       <= ptr_nxt;
      drive_lat <= drive_lat_nxt;
      cnt       <= cnt_nxt;
      turn_cnt  <= turn_cnt_nxt;
      gnt_q     <= gnt_nxt;
      out_q     <= out_nxt;
      oe_q      <= oe_nxt;
      rdata_q   <= rdata_nxt;
      rvalid_q  <= rvalid_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    ptr_nxt       = ptr;
    drive_lat_nxt = drive_lat;
    cnt_nxt       = cnt;
    turn_cnt_nxt  = turn_cnt;
    gnt_nxt       = gnt_q;
    out_nxt       = out_q;
    oe_nxt        = 8'h00;
    rdata_nxt     = rdata_q;
    rvalid_nxt    = '0;
    cnt_inc       = cnt + CNT_W'(1);
    pick          = rr_pick(bus.req, ptr);

    unique case (state)
      ARB: begin
        gnt_nxt = '0;
        if (ena && (|bus.req)) begin
          owner_nxt     = pick;
          drive_lat_nxt = bus.drive[pick];
          cnt_nxt       = '0;
          ptr_nxt       = (pick == IDX_W'(N_REQ - 1)) ? '0 : pick + IDX_W'(1);
          gnt_nxt       = one_hot(pick);
          state_nxt     = OWN;
        end
      end
      OWN: begin
        if (!bus.req[owner]) begin
          state_nxt    = TURN;
          gnt_nxt      = '0;
          turn_cnt_nxt = TURN_W'(TURN_CYC);
        end else begin
          if (drive_lat) begin
            out_nxt = bus.wdata[8*int'(owner) +: 8];
            oe_nxt  = 8'hFF;
          end else begin
            rdata_nxt  = uio_in;
            rvalid_nxt = one_hot(owner);
          end
          cnt_nxt = (cnt == CNT_W'(HOLD_MAX)) ? cnt : cnt_inc;
          // Forced release once this beat uses up the grant's beat budget.
          if (bus.last[owner] || (cnt_inc == CNT_W'(HOLD_MAX))) begin
            state_nxt    = TURN;
            gnt_nxt      = '0;
            turn_cnt_nxt = TURN_W'(TURN_CYC);
          end
        end
      end
      TURN: begin
        gnt_nxt = '0;
        if (turn_cnt <= TURN_W'(1)) begin
          turn_cnt_nxt = '0;
          state_nxt    = ARB;
        end else begin
          turn_cnt_nxt = turn_cnt - TURN_W'(1);
        end
      end
      default: begin
        state_nxt = ARB;
        gnt_nxt   = '0;
      end
    endcase
  end

  assign uio_out    = out_q;
  assign uio_oe     = oe_q;
  assign bus.gnt    = gnt_q;
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed self-checking bench for uio_bus_arbiter (N_REQ=3, HOLD_MAX=4,
// TURN_CYC=1) with hand-computed expected values per clock edge.
module tb_uio_bus_arbiter;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int nChecks;
  int nFails;

  uio_bus_arbiter_if #(.N_REQ(3)) bus ();

  uio_bus_arbiter #(
    .N_REQ(3),
    .HOLD_MAX(4),
    .TURN_CYC(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .uio_in(uio_in),
    .uio_out(uio_out),
    .uio_oe(uio_oe),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Round-robin with every request held and single-beat transfers.
  logic [2:0] rrGnt [13] = '{3'b001, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000,
                             3'b100, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000,
                             3'b010};
  // Single write: stimulus before each edge and outputs after it.
  logic       swReq  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic       swLast [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [2:0] swGnt  [6] = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000};
  logic [7:0] swOe   [6] = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};
  logic [7:0] swOut  [6] = '{8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
  // Forced release after four beats each to requesters 0 and 1.
  logic [2:0] frGnt [13] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000,
                             3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000,
                             3'b001};
  logic [7:0] frOe  [13] = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00,
                             8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00,
                             8'h00};
  logic [7:0] frOut [13] = '{8'h00, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11,
                             8'h11, 8'h22, 8'h22, 8'h22, 8'h22, 8'h22,
                             8'h22};

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] r, input logic [2:0] d,
                               input logic [2:0] l, input logic [23:0] wd,
                               input logic [7:0] ui, input logic e);
    bus.req   = r;
    bus.drive = d;
    bus.last  = l;
    bus.wdata = wd;
    uio_in    = ui;
    ena       = e;
  endtask

  // Advance one edge; outputs are then read 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(3'b000, 3'b000, 3'b000, 24'h0, 8'h00, 1'b1);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    rst     = 1'b1;
    applyStimulus(3'b111, 3'b000, 3'b111, 24'h0, 8'h5A, 1'b1);
    tick();
    tick();
    checkOutput("reset_gnt", 32'(bus.gnt), 32'h0);
    checkOutput("reset_oe", 32'(uio_oe), 32'h0);
    checkOutput("reset_out", 32'(uio_out), 32'h0);
    checkOutput("reset_rdata", 32'(bus.rdata), 32'h0);
    checkOutput("reset_rvalid", 32'(bus.rvalid), 32'h0);

    rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      tick();
      checkOutput($sformatf("rr_gnt_%0d", i), 32'(bus.gnt), 32'(rrGnt[i]));
    end

    resetDut();
    for (int i = 0; i < 6; i++) begin
      applyStimulus({2'b00, swReq[i]}, 3'b001, {2'b00, swLast[i]}, 24'h0000A5,
                    8'h00, 1'b1);
      tick();
      checkOutput($sformatf("wr_gnt_%0d", i), 32'(bus.gnt), 32'(swGnt[i]));
      checkOutput($sformatf("wr_oe_%0d", i), 32'(uio_oe), 32'(swOe[i]));
      checkOutput($sformatf("wr_out_%0d", i), 32'(uio_out), 32'(swOut[i]));
    end

    resetDut();
    applyStimulus(3'b010, 3'b000, 3'b010, 24'h0, 8'h3C, 1'b1);
    tick();
    checkOutput("rd_gnt", 32'(bus.gnt), 32'h2);
    checkOutput("rd_rvalid_pre", 32'(bus.rvalid), 32'h0);
    tick();
    checkOutput("rd_rdata", 32'(bus.rdata), 32'h3C);
    checkOutput("rd_rvalid", 32'(bus.rvalid), 32'h2);
    checkOutput("rd_oe", 32'(uio_oe), 32'h0);
    checkOutput("rd_gnt_off", 32'(bus.gnt), 32'h0);
    applyStimulus(3'b000, 3'b000, 3'b000, 24'h0, 8'h55, 1'b1);
    tick();
    checkOutput("rd_rvalid_post", 32'(bus.rvalid), 32'h0);
    checkOutput("rd_rdata_hold", 32'(bus.rdata), 32'h3C);
    checkOutput("rd_oe_post", 32'(uio_oe), 32'h0);

    resetDut();
    applyStimulus(3'b011, 3'b011, 3'b000, 24'h002211, 8'h00, 1'b1);
    for (int i = 0; i < 13; i++) begin
      tick();
      checkOutput($sformatf("fr_gnt_%0d", i), 32'(bus.gnt), 32'(frGnt[i]));
      checkOutput($sformatf("fr_oe_%0d", i), 32'(uio_oe), 32'(frOe[i]));
      checkOutput($sformatf("fr_out_%0d", i), 32'(uio_out), 32'(frOut[i]));
    end

    resetDut();
    applyStimulus(3'b001, 3'b001, 3'b000, 24'h000077, 8'h00, 1'b1);
    tick();
    tick();
    checkOutput("ab_gnt_beat", 32'(bus.gnt), 32'h1);
    checkOutput("ab_oe_beat", 32'(uio_oe), 32'hFF);
    applyStimulus(3'b000, 3'b001, 3'b000, 24'h000077, 8'h00, 1'b1);
    tick();
    checkOutput("ab_gnt_turn", 32'(bus.gnt), 32'h0);
    checkOutput("ab_oe_turn", 32'(uio_oe), 32'h0);
    checkOutput("ab_out_hold", 32'(uio_out), 32'h77);
    tick();
    checkOutput("ab_gnt_arb", 32'(bus.gnt), 32'h0);

    resetDut();
    applyStimulus(3'b100, 3'b000, 3'b000, 24'h0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("en_blocked_%0d", i), 32'(bus.gnt), 32'h0);
    end
    ena = 1'b1;
    tick();
    checkOutput("en_grant", 32'(bus.gnt), 32'h4);
    ena = 1'b0;
    tick();
    checkOutput("en_midxfer_gnt", 32'(bus.gnt), 32'h4);
    checkOutput("en_midxfer_rvalid", 32'(bus.rvalid), 32'h4);
    bus.last = 3'b100;
    tick();
    checkOutput("en_release", 32'(bus.gnt), 32'h0);

    resetDut();
    applyStimulus(3'b001, 3'b001, 3'b000, 24'h0000C3, 8'h00, 1'b1);
    tick();
    tick();
    checkOutput("rs_oe_beat", 32'(uio_oe), 32'hFF);
    checkOutput("rs_out_beat", 32'(uio_out), 32'hC3);
    rst = 1'b1;
    tick();
    checkOutput("rs_oe", 32'(uio_oe), 32'h0);
    checkOutput("rs_gnt", 32'(bus.gnt), 32'h0);
    checkOutput("rs_out", 32'(uio_out), 32'h0);
    rst = 1'b0;
    bus.req = 3'b011;
    tick();
    checkOutput("rs_ptr_regrant", 32'(bus.gnt), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
